// File: rtl/metronome_pkg.sv
// Shared metronome types: BPM bounds, sequencer FSM states, step codes and
// small BPM arithmetic helpers.
package metronome_pkg;

  localparam int unsigned BPM_W         = 8;
  localparam int unsigned DIFF_W        = 9;
  localparam int unsigned BPM_MIN_DEF   = 30;
  localparam int unsigned BPM_MAX_DEF   = 250;
  localparam int unsigned BPM_RESET_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_GAP
  } seq_state_e;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_P1,
    STEP_P5,
    STEP_M1,
    STEP_M5
  } step_e;

  // Clamp an 8-bit BPM request into [lo, hi]
  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] val,
                                                 input logic [BPM_W-1:0] lo,
                                                 input logic [BPM_W-1:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  // Signed BPM change carried by a step code
  function automatic logic signed [DIFF_W-1:0] step_delta(input step_e s);
    case (s)
      STEP_P1: return 9'sd1;
      STEP_P5: return 9'sd5;
      STEP_M1: return -9'sd1;
      STEP_M5: return -9'sd5;
      default: return 9'sd0;
    endcase
  endfunction

  // Apply a step to a BPM value, saturating at [lo, hi]
  function automatic logic [BPM_W-1:0] apply_step(input logic [BPM_W-1:0] bpm,
                                                  input step_e            s,
                                                  input logic [BPM_W-1:0] lo,
                                                  input logic [BPM_W-1:0] hi);
    logic signed [DIFF_W-1:0] sum;
    logic signed [DIFF_W-1:0] lo_s;
    logic signed [DIFF_W-1:0] hi_s;
    sum  = $signed({1'b0, bpm}) + step_delta(s);
    lo_s = $signed({1'b0, lo});
    hi_s = $signed({1'b0, hi});
    if (sum < lo_s) return lo;
    if (sum > hi_s) return hi;
    return sum[BPM_W-1:0];
  endfunction

endpackage

// File: rtl/bpm_step_planner.sv
// Chooses the next metronome step that moves current toward target:
// coarse 5-steps while at least 5 away, then single steps.
module bpm_step_planner
  import metronome_pkg::*;
(
  input  logic [BPM_W-1:0] current,
  input  logic [BPM_W-1:0] target,
  output step_e            step_c
);

  logic signed [DIFF_W-1:0] diff_c;

  // Signed distance to target selects step size and direction
  always_comb begin
    diff_c = $signed({1'b0, target}) - $signed({1'b0, current});
    step_c = STEP_NONE;
    if (diff_c >= 9'sd5)       step_c = STEP_P5;
    else if (diff_c >= 9'sd1)  step_c = STEP_P1;
    else if (diff_c <= -9'sd5) step_c = STEP_M5;
    else if (diff_c <= -9'sd1) step_c = STEP_M1;
  end

endmodule

// File: rtl/bpm_cmd_sequencer.sv
// Converts target-BPM commands into spaced +/-1/+/-5 step pulses for the
// metronome, forwards button pulses when idle and mirrors the metronome BPM.
// Optional macro BTN_ABORT_EN: a button press during a running sequence ends
// it at the next gap expiry.
module bpm_cmd_sequencer
  import metronome_pkg::*;
#(
  parameter int unsigned BPM_MIN   = BPM_MIN_DEF,
  parameter int unsigned BPM_MAX   = BPM_MAX_DEF,
  parameter int unsigned BPM_RESET = BPM_RESET_DEF,
  parameter int unsigned PULSE_GAP = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_plus_1,
  input  logic             i_btn_plus_5,
  input  logic             i_btn_minus_1,
  input  logic             i_btn_minus_5,
  input  logic             i_cmd_valid,
  input  logic [BPM_W-1:0] i_cmd_bpm,
  output logic             o_cmd_ready,
  output logic             o_plus_1,
  output logic             o_plus_5,
  output logic             o_minus_1,
  output logic             o_minus_5,
  output logic [BPM_W-1:0] o_bpm,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [BPM_W-1:0] MIN_B    = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] MAX_B    = BPM_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] RESET_B  = BPM_W'(BPM_RESET);
  localparam logic [7:0]       GAP_LOAD = 8'(PULSE_GAP - 1);

  seq_state_e       state_q, state_d;
  logic [BPM_W-1:0] cmd_q, cmd_d;
  logic [BPM_W-1:0] target_q, target_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic [7:0]       gap_q, gap_d;
  step_e            step_d;
  logic             done_d;
  logic             ready_q, busy_q, done_q;
  logic [3:0]       pulse_q;

  logic [BPM_W-1:0] clamp_c;
  logic [BPM_W-1:0] plan_target_c;
  step_e            plan_step_c;
  step_e            btn_step_c;
  logic             btn_any_c;
  logic             abort_c;

  assign btn_any_c     = i_btn_plus_1 | i_btn_plus_5 | i_btn_minus_1 | i_btn_minus_5;
  assign clamp_c       = clamp_bpm(cmd_q, MIN_B, MAX_B);
  assign plan_target_c = (state_q == ST_CALC) ? clamp_c : target_q;

  // Button priority when several arrive together: +5 > +1 > -5 > -1
  always_comb begin
    btn_step_c = STEP_NONE;
    if (i_btn_plus_5)       btn_step_c = STEP_P5;
    else if (i_btn_plus_1)  btn_step_c = STEP_P1;
    else if (i_btn_minus_5) btn_step_c = STEP_M5;
    else if (i_btn_minus_1) btn_step_c = STEP_M1;
  end

  bpm_step_planner u_planner (
    .current (bpm_q),
    .target  (plan_target_c),
    .step_c  (plan_step_c)
  );

`ifdef BTN_ABORT_EN
  logic abort_q;

  // Latch any button press seen mid-sequence until the sequence ends
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      abort_q <= 1'b0;
    end else if (state_q == ST_IDLE || state_q == ST_CALC) begin
      abort_q <= 1'b0;
    end else if (btn_any_c) begin
      abort_q <= 1'b1;
    end
  end

  assign abort_c = abort_q | btn_any_c;
`else
  assign abort_c = 1'b0;
`endif

  // Next-state, step selection and mirror update
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    target_d = target_q;
    gap_d    = gap_q;
    step_d   = STEP_NONE;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && ready_q) begin
          cmd_d   = i_cmd_bpm;
          state_d = ST_CALC;
        end else if (btn_any_c) begin
          step_d = btn_step_c;
        end
      end
      ST_CALC: begin
        target_d = clamp_c;
        if (plan_step_c == STEP_NONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          step_d  = plan_step_c;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          if (abort_c || plan_step_c == STEP_NONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            step_d  = plan_step_c;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bpm_d = apply_step(bpm_q, step_d, MIN_B, MAX_B);
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= RESET_B;
      target_q <= RESET_B;
      bpm_q    <= RESET_B;
      gap_q    <= 8'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      target_q <= target_d;
      bpm_q    <= bpm_d;
      gap_q    <= gap_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
      pulse_q  <= {step_d == STEP_P5, step_d == STEP_P1,
                   step_d == STEP_M5, step_d == STEP_M1};
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_bpm       = bpm_q;
  assign o_plus_5    = pulse_q[3];
  assign o_plus_1    = pulse_q[2];
  assign o_minus_5   = pulse_q[1];
  assign o_minus_1   = pulse_q[0];

endmodule
